// File: rtl/trig_pulse_meter.sv
// trig_pulse_meter: measures the length of each trigger pulse in ext_clock cycles,
// counts completed pulses, and presents every measurement through a valid/ack
// capture slot with a sticky overrun flag.
//
// Optional build macro: TRIG_FILTER_EN adds a glitch filter on trig_in
// (pFILTER_LEN stable samples required, both edges delayed equally).
//
// Ports:
//   ext_clock      block clock
//   fpga_reset     asynchronous active-high reset
//   trig_in        trigger, synchronous to ext_clock
//   arm            enable; low holds the block idle with counters/overrun cleared
//   capture_ack    consumer acknowledge of the capture slot
//   cycles_out     length of the last captured pulse
//   trig_count     completed pulses since arm rose (wraps)
//   capture_valid  cycles_out holds an unacknowledged measurement
//   overrun        sticky: a pulse completed while the slot was occupied
//   busy           a pulse is being measured
module trig_pulse_meter #(
    parameter int unsigned pCNT_WIDTH     = 32,
    parameter int unsigned pTRIGCNT_WIDTH = 16,
    parameter int unsigned pFILTER_LEN    = 2
) (
    input  logic                      ext_clock,
    input  logic                      fpga_reset,
    input  logic                      trig_in,
    input  logic                      arm,
    input  logic                      capture_ack,
    output logic [pCNT_WIDTH-1:0]     cycles_out,
    output logic [pTRIGCNT_WIDTH-1:0] trig_count,
    output logic                      capture_valid,
    output logic                      overrun,
    output logic                      busy
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_COUNT = 1'b1;

    // Filter length must fit the 4-bit stability counter.
    if (pFILTER_LEN < 1 || pFILTER_LEN > 15) begin : g_bad_filter_len
        $error("trig_pulse_meter: pFILTER_LEN out of range 1..15");
    end

    logic trig_s;

`ifdef TRIG_FILTER_EN
    logic       filt_q, filt_d;
    logic [3:0] stab_q, stab_d;

    // Output follows trig_in only after pFILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        stab_d = 4'd0;
        if (trig_in != filt_q) begin
            if (stab_q == 4'(pFILTER_LEN - 1)) begin
                filt_d = trig_in;
            end else begin
                stab_d = stab_q + 4'd1;
            end
        end
    end

    // Resets high so a trigger already asserted at reset release is not a rise.
    always_ff @(posedge ext_clock or posedge fpga_reset) begin
        if (fpga_reset) begin
            filt_q <= 1'b1;
            stab_q <= 4'd0;
        end else begin
            filt_q <= filt_d;
            stab_q <= stab_d;
        end
    end

    assign trig_s = filt_q;
`else
    assign trig_s = trig_in;
`endif

    logic                      state_q, state_d;
    logic                      trig_q;
    logic [pCNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic [pCNT_WIDTH-1:0]     cycles_q, cycles_d;
    logic [pTRIGCNT_WIDTH-1:0] tcnt_q, tcnt_d;
    logic                      valid_q, valid_d;
    logic                      ovr_q, ovr_d;
    logic                      rise, fall;

    assign rise = trig_s & ~trig_q;
    assign fall = ~trig_s & trig_q;

    // Next-state, counter and capture-slot logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        tcnt_d   = tcnt_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;

        if (capture_ack && valid_q) begin
            valid_d = 1'b0;
        end

        if (!arm) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            tcnt_d  = '0;
            ovr_d   = 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (rise) begin
                cnt_d   = pCNT_WIDTH'(1);
                state_d = ST_COUNT;
            end
        end else begin
            if (fall) begin
                state_d = ST_IDLE;
                tcnt_d  = tcnt_q + pTRIGCNT_WIDTH'(1);
                // An ack in the same cycle frees the slot; the new capture wins.
                if (!valid_q || capture_ack) begin
                    cycles_d = cnt_q;
                    valid_d  = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end else if (trig_s && (cnt_q != '1)) begin
                cnt_d = cnt_q + pCNT_WIDTH'(1);
            end
        end
    end

    // History register resets high to suppress a rise on reset release.
    always_ff @(posedge ext_clock or posedge fpga_reset) begin
        if (fpga_reset) begin
            state_q  <= ST_IDLE;
            trig_q   <= 1'b1;
            cnt_q    <= '0;
            cycles_q <= '0;
            tcnt_q   <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            trig_q   <= trig_s;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
            tcnt_q   <= tcnt_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign cycles_out    = cycles_q;
    assign trig_count    = tcnt_q;
    assign capture_valid = valid_q;
    assign overrun       = ovr_q;
    assign busy          = (state_q == ST_COUNT);

endmodule
